// File: rtl/rom_to_ram_dma.sv
// rom_to_ram_dma
//
// Restartable block-copy engine between a synchronous image ROM and a
// frame-buffer RAM write port. In copy mode it streams `length` words from
// ROM[src_base..] into RAM[dst_base..] at one word per clock. In fill mode
// it writes `fill_value` into RAM[dst_base..] for `length` words. All
// transfer parameters are captured on the accepting start edge, and address
// arithmetic wraps modulo 2^ADDR_W.
//
// Parameters:
//   DATA_W   word width of ROM and RAM data
//   ADDR_W   ROM/RAM address width
//   ROM_LAT  ROM read latency in clock edges (1..4)
//
// Ports:
//   clk         clock, all logic on the rising edge
//   reset       asynchronous, active-low reset
//   start       transfer request, honoured only while idle
//   mode        0 = copy ROM->RAM, 1 = fill RAM with fill_value
//   src_base    first ROM address
//   dst_base    first RAM address
//   length      number of words to transfer, 0..2^ADDR_W
//   fill_value  word written in fill mode
//   rom_addr    registered ROM read address
//   rom_data    ROM read data, ROM_LAT edges behind rom_addr
//   ram_wraddr  registered RAM write address
//   ram_data    registered RAM write data
//   ram_wren    registered RAM write enable
//   busy        high from an accepted start until completion
//   done        sticky completion flag, cleared by the next accepted start

module rom_to_ram_dma #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 19,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] fill_value,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              done
);

  // One tag stage per ROM latency edge, plus the stage that holds the
  // address being presented to the ROM right now.
  localparam int DEPTH = ROM_LAT + 1;

  localparam logic [ADDR_W:0]   LEN_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t state, state_next;

  // Captured transfer parameters and progress counters
  logic              mode_reg;
  logic [DATA_W-1:0] fill_reg;
  logic [ADDR_W:0]   remain;     // words still to issue after the current one
  logic [ADDR_W-1:0] dst_next;   // destination of the next word to issue

  // Valid tags and their destination addresses, stage 0 = just issued
  logic [DEPTH-1:0]  vld;
  logic [DEPTH-1:0]  vld_next;
  logic [ADDR_W-1:0] dst_pipe [DEPTH];

  logic              accept;
  logic              issue;
  logic              finish;
  logic              wr_fire;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // --------------------------------------------------------------------
  // Next-state and control decode
  // --------------------------------------------------------------------
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    issue      = 1'b0;
    finish     = 1'b0;
    vld_next   = '0;
    wr_fire    = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;

    accept = (state == IDLE) && start;
    issue  = (state == ISSUE) && (remain != '0);
    // The pipeline being empty in DRAIN means the final write has just
    // been presented for one cycle.
    finish = (state == DRAIN) && (vld == '0);

    case (state)
      IDLE: begin
        // A zero-length request completes on the accepting edge itself.
        if (start && (length != '0)) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        // remain <= 1 means this cycle issues the last word (or none is left
        // when the whole run was a single word issued on the start edge).
        if (remain[ADDR_W:1] == '0) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (vld == '0) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // The first word is issued on the accepting edge, the rest in ISSUE.
    vld_next[0] = accept ? (length != '0) : issue;
    // Fill mode writes straight from stage 0, so its tags are not carried
    // further; this keeps stale tags from reaching the tail of a later copy.
    for (int i = 1; i < DEPTH; i++) begin
      vld_next[i] = mode_reg ? 1'b0 : vld[i-1];
    end

    if (mode_reg) begin
      wr_fire = vld[0];
      wr_addr = dst_pipe[0];
      wr_data = fill_reg;
    end else begin
      wr_fire = vld[DEPTH-1];
      wr_addr = dst_pipe[DEPTH-1];
      wr_data = rom_data;
    end
  end

  // --------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------
  // Datapath, tag pipeline and status flags
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_reg   <= 1'b0;
      fill_reg   <= '0;
      remain     <= '0;
      dst_next   <= '0;
      vld        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dst_pipe[i] <= '0;
      end
      rom_addr   <= '0;
      ram_wraddr <= '0;
      ram_data   <= '0;
      ram_wren   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      vld <= vld_next;
      for (int i = 1; i < DEPTH; i++) begin
        dst_pipe[i] <= dst_pipe[i-1];
      end

      if (accept) begin
        mode_reg    <= mode;
        fill_reg    <= fill_value;
        rom_addr    <= src_base;
        remain      <= length - LEN_ONE;
        dst_pipe[0] <= dst_base;
        dst_next    <= dst_base + ADDR_ONE;
        busy        <= (length != '0);
        done        <= (length == '0);
      end else if (issue) begin
        // The ROM address only advances in copy mode; fill holds it.
        if (!mode_reg) begin
          rom_addr <= rom_addr + ADDR_ONE;
        end
        remain      <= remain - LEN_ONE;
        dst_pipe[0] <= dst_next;
        dst_next    <= dst_next + ADDR_ONE;
      end

      if (finish) begin
        busy <= 1'b0;
        done <= 1'b1;
      end

      // Address and data hold their last values whenever nothing is written.
      ram_wren <= wr_fire;
      if (wr_fire) begin
        ram_wraddr <= wr_addr;
        ram_data   <= wr_data;
      end
    end
  end

endmodule
